// File: rtl/dfc_result_collector_if.sv
// Port bundle for dfc_result_collector: upstream word capture, buffered
// valid/ready output, per-frame summary and overflow status.
interface dfc_result_collector_if #(
  parameter int DEPTH = 8
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [8:0]    din;
  logic          din_valid;
  // Output handshake: out_valid is asserted whenever the FIFO holds a word.
  // A word transfers in any cycle where out_valid & out_ready are both high.
  // out_data stays stable while out_valid is high and out_ready is low.
  logic [8:0]    out_data;
  logic          out_valid;
  logic          out_ready;
  logic [LW-1:0] level;
  logic          frame_done;
  logic [2:0]    frame_len;
  logic [10:0]   frame_sum;
  logic [8:0]    frame_max;
  logic          overflow;
  logic          ovf_clr;

  modport slave (
    input  din, din_valid, out_ready, ovf_clr,
    output out_data, out_valid, level, frame_done, frame_len, frame_sum,
           frame_max, overflow
  );

  modport master (
    output din, din_valid, out_ready, ovf_clr,
    input  out_data, out_valid, level, frame_done, frame_len, frame_sum,
           frame_max, overflow
  );
endinterface

// File: rtl/dfc_result_collector.sv
// Captures controller result bursts into a FIFO and reports per-frame
// count/sum/max. Define DFC_COLLECT_MAX_EN to build the frame max tracker.
module dfc_result_collector #(
  parameter int DEPTH     = 8,
  parameter int FRAME_LEN = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic [1:0]           dbg_state,
  dfc_result_collector_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, COLLECT = 2'd1, REPORT = 2'd2} state_t;

  state_t        state;
  logic [8:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] count;
  logic          rd;
  logic          wr;
  logic          full;
  logic          rpt;
  logic [2:0]    cnt_q;
  logic [2:0]    cnt_nxt;
  logic [10:0]   sum_q;
  logic [10:0]   sum_nxt;
  logic          first;

  assign dbg_state     = state;
  assign full          = (count == LW'(DEPTH));
  assign rd            = bus.out_valid & bus.out_ready;
  // A read in the same cycle frees the slot, so a full FIFO can still accept.
  assign wr            = bus.din_valid & (~full | rd);
  assign bus.out_valid = (count != '0);
  assign bus.out_data  = bus.out_valid ? mem[rd_ptr] : '0;
  assign bus.level     = count;

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= bus.din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      bus.overflow <= 1'b0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (rd) rd_ptr <= rd_ptr + 1'b1;
      case ({wr, rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (bus.din_valid & ~wr) bus.overflow <= 1'b1;
      else if (bus.ovf_clr)    bus.overflow <= 1'b0;
    end
  end

  // Any word seen outside COLLECT opens a fresh frame, including the REPORT cycle.
  assign first   = (state != COLLECT);
  assign cnt_nxt = first ? 3'd1 : cnt_q + 3'd1;
  assign sum_nxt = first ? {2'b00, bus.din} : sum_q + {2'b00, bus.din};
  assign rpt     = (state == COLLECT) &&
                   (!bus.din_valid || cnt_nxt == 3'(FRAME_LEN));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      bus.frame_done <= 1'b0;
    end else begin
      bus.frame_done <= rpt;
      case (state)
        IDLE:    if (bus.din_valid) state <= COLLECT;
        COLLECT: if (rpt) state <= REPORT;
        REPORT:  state <= bus.din_valid ? COLLECT : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q         <= '0;
      sum_q         <= '0;
      bus.frame_len <= '0;
      bus.frame_sum <= '0;
    end else begin
      if (bus.din_valid) begin
        cnt_q <= cnt_nxt;
        sum_q <= sum_nxt;
      end
      if (rpt) begin
        bus.frame_len <= bus.din_valid ? cnt_nxt : cnt_q;
        bus.frame_sum <= bus.din_valid ? sum_nxt : sum_q;
      end
    end
  end

`ifdef DFC_COLLECT_MAX_EN
  logic [8:0] max_q;
  logic [8:0] max_nxt;

  assign max_nxt = (first || bus.din > max_q) ? bus.din : max_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      max_q         <= '0;
      bus.frame_max <= '0;
    end else begin
      if (bus.din_valid) max_q <= max_nxt;
      if (rpt) bus.frame_max <= bus.din_valid ? max_nxt : max_q;
    end
  end
`else
  assign bus.frame_max = '0;
`endif
endmodule

// File: doc/dfc_result_collector.md
# dfc_result_collector

Downstream stage of the data-flow controller: captures the 9-bit pairwise-sum words the controller emits as 4-cycle `output_valid` bursts. It buffers them in a small FIFO and hands them out through a valid/ready port. It also produces per-frame summary data: word count, 11-bit sum and, optionally, the maximum word. The controller cannot be stalled, so the block drops words on overflow and flags the loss.

## Interface
- `DEPTH`, 8, FIFO entries; power of two, ≥4.
- `FRAME_LEN`, 4, maximum words per frame; fixed by the upstream burst length.
- `clk` input 1 — clock, rising edge.
- `reset` input 1 — reset, asynchronous, active-high; clock `clk`.
- `din` input 9 — word from upstream `dataout`.
- `din_valid` input 1 — upstream `output_valid`; `din` is sampled on every cycle it is high.
- `out_data` output 9 — FIFO head word.
- `out_valid` output 1 — FIFO non-empty.
- `out_ready` input 1 — consumer accepts the head word in a cycle where `out_valid & out_ready`.
- `level` output log2(DEPTH)+1 — current FIFO occupancy.
- `frame_done` output 1 — one-cycle pulse; the summary outputs are valid in this cycle and held afterwards.
- `frame_len` output 3 — number of words in the completed frame.
- `frame_sum` output 11 — unsigned sum of the frame's words.
- `frame_max` output 9 — largest word in the frame.
- `overflow` output 1 — sticky flag: at least one word was dropped.
- `ovf_clr` input 1 — synchronous clear of `overflow`.

## Operation
- FSM states:
  - IDLE to COLLECT on `din_valid`.
  - COLLECT to REPORT when the word count reaches FRAME_LEN, or when `din_valid` is low.
  - REPORT to COLLECT if `din_valid` is high; otherwise REPORT to IDLE.
- The word that arrives in the REPORT cycle starts a new frame, so back-to-back frames lose no words.
- Accumulation:
  - The first word of a frame loads the accumulators: sum = din, max = din, cnt = 1.
  - Each later word updates them: sum += din, max = max(max, din), cnt += 1.
  - The sum is zero-extended to 11 bits; 4×511 = 2044 cannot wrap.
- Summary outputs `frame_len`, `frame_sum` and `frame_max` are registered on entry to REPORT. `frame_done` is high only in REPORT.
- FIFO write rule:
  - A word is written when `din_valid` is high and either the FIFO is not full or a read occurs in the same cycle.
  - Otherwise the word is dropped and `overflow` is set.
  - Dropped words still count toward the frame summary.
- FIFO read: occurs when `out_valid & out_ready`. Pointers wrap modulo DEPTH. `level` changes by +1, -1 or 0.
- Overflow priority: a drop in the same cycle as `ovf_clr` leaves `overflow` = 1 (set wins).

## Timing
- Reset values: every output is 0, the FSM is in IDLE, and the FIFO is empty.
- Reset mid-frame discards the partial frame and all buffered words.
- FIFO write latency: a word sampled at the edge ending cycle T appears on `out_data`/`out_valid` in cycle T+1 if the FIFO was empty.
- `out_data` is held stable while `out_valid & !out_ready`.
- Frame ended by count: FRAME_LEN-th word in cycle T → `frame_done` in T+1.
- Frame ended by gap: last word in cycle T, `din_valid` low in T+1 → `frame_done` in T+2.
- One frame is reported per REPORT cycle. `frame_done` never occurs without at least one word.

## Configuration
- `DFC_COLLECT_MAX_EN` defined: the max tracker and comparator are present, and `frame_max` behaves as specified above.
- `DFC_COLLECT_MAX_EN` undefined: the comparator and register are removed, and `frame_max` is tied to 0. All other behaviour is unchanged.

## Test plan
- Single burst: `din` = 0x010, 0x020, 0x030, 0x1FE on 4 consecutive cycles, `out_ready` = 1.
  - Outputs appear in the same order, one cycle after input.
  - `frame_done` occurs 1 cycle after the 4th word, with `frame_len` = 4, `frame_sum` = 0x25E, `frame_max` = 0x1FE (0 when the macro is off).
- Short frame: 2 words, 0x005 and 0x003, then a gap.
  - `frame_done` occurs 2 cycles after the last word.
  - `frame_len` = 2, `frame_sum` = 0x008, `frame_max` = 0x005.
- Back-to-back: 8 consecutive valid words, each 0x1FF.
  - Two `frame_done` pulses, each with `frame_sum` = 0x7FC and `frame_len` = 4.
  - No word is lost; the 5th word arrives in the REPORT cycle.
- Overflow: `out_ready` = 0, three 4-word bursts separated by idle cycles.
  - `level` saturates at 8 and the last 4 words are dropped.
  - `overflow` = 1, and the third frame's summary is still correct.
  - `ovf_clr` then clears `overflow`.
- Full with simultaneous read: FIFO full, then `din_valid` = 1 and `out_ready` = 1 in the same cycle.
  - The word is accepted, `level` stays at 8 and `overflow` stays 0.
- Reset asserted after the 2nd word of a frame.
  - All outputs return to 0 immediately.
  - The next burst produces a clean `frame_len` = 4 summary.
